// File: rtl/ysyx_25050147_lsu_ctrl.sv
// Load/store sequencer between EXU and the data-memory bus: alignment check, lane steering, load extension.
// Optional macro YSYX_25050147_LSU_PERF_EN adds load/store/wait performance counters.
module ysyx_25050147_lsu_ctrl #(
    parameter int TAG_W = 5
`ifdef YSYX_25050147_LSU_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_wen,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    output logic [3:0]       mem_req_wmask,
    input  logic             mem_resp_valid,
    output logic             mem_resp_ready,
    input  logic [31:0]      mem_resp_rdata,
    input  logic             mem_resp_err
`ifdef YSYX_25050147_LSU_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_ld_cnt,
    output logic [PERF_W-1:0] perf_st_cnt,
    output logic [PERF_W-1:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;

    logic             wen_q;
    logic [2:0]       op_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic             req_bad;
    logic [3:0]       mask;
    logic [31:0]      lane_bits;

    function automatic logic op_bad(input logic wen, input logic [2:0] op, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (wen)
            illegal = op[2] || (op[1:0] == 2'b11);
        else
            illegal = (op[1:0] == 2'b11) || (op == 3'b110);
        misaligned = ((op[1:0] == 2'b01) && a[0]) || ((op[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] word,
                                             input logic [1:0] off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (op)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign req_bad = op_bad(req_wen, req_op, req_addr[1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid)      state_nxt = req_bad ? S_RESP : S_REQ;
            S_REQ:  if (mem_req_ready)  state_nxt = S_WAIT;
            S_WAIT: if (mem_resp_valid) state_nxt = S_RESP;
            S_RESP: if (resp_ready)     state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Transaction context; outputs are gated by state, so these need no reset.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && req_valid) begin
            wen_q   <= req_wen;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
            err_q   <= req_bad;
            rdata_q <= 32'd0;
        end else if (state == S_WAIT && mem_resp_valid) begin
            err_q   <= mem_resp_err;
            rdata_q <= (wen_q || mem_resp_err) ? 32'd0 : load_ext(op_q, mem_resp_rdata, addr_q[1:0]);
        end
    end

    always_comb begin
        case (op_q[1:0])
            2'b00:   mask = 4'b0001 << addr_q[1:0];
            2'b01:   mask = 4'b0011 << addr_q[1:0];
            default: mask = 4'b1111;
        endcase
        lane_bits = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    end

    always_comb begin
        req_ready      = reset_n && (state == S_IDLE);
        mem_req_valid  = 1'b0;
        mem_req_wen    = 1'b0;
        mem_req_addr   = 32'd0;
        mem_req_wdata  = 32'd0;
        mem_req_wmask  = 4'd0;
        mem_resp_ready = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'd0;
        resp_tag       = '0;
        resp_err       = 1'b0;
        case (state)
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = wen_q;
                mem_req_addr  = {addr_q[31:2], 2'b00};
                mem_req_wmask = mask;
                if (wen_q)
                    mem_req_wdata = (wdata_q << {addr_q[1:0], 3'b000}) & lane_bits;
            end
            S_WAIT: mem_resp_ready = 1'b1;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_tag   = tag_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

`ifdef YSYX_25050147_LSU_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_ld_cnt   <= '0;
            perf_st_cnt   <= '0;
            perf_wait_cnt <= '0;
        end else begin
            if (state == S_REQ || state == S_WAIT)
                perf_wait_cnt <= perf_wait_cnt + 1'b1;
            if (state == S_WAIT && mem_resp_valid) begin
                if (wen_q) perf_st_cnt <= perf_st_cnt + 1'b1;
                else       perf_ld_cnt <= perf_ld_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25050147_lsu_ctrl.sv
// Bench for ysyx_25050147_lsu_ctrl: directed vector table, hand-written corner sequences, random ops vs a reference model.
module tb_ysyx_25050147_lsu_ctrl;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             req_valid = 1'b0, req_ready, req_wen = 1'b0;
    logic [2:0]       req_op = '0;
    logic [31:0]      req_addr = '0, req_wdata = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0]      resp_rdata;
    logic [TAG_W-1:0] resp_tag;
    logic             mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0]      mem_req_addr, mem_req_wdata;
    logic [3:0]       mem_req_wmask;
    logic             mem_resp_valid = 1'b0, mem_resp_ready, mem_resp_err = 1'b0;
    logic [31:0]      mem_resp_rdata = '0;
`ifdef YSYX_25050147_LSU_PERF_EN
    logic [31:0]      perf_ld_cnt, perf_st_cnt, perf_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        merr;
        logic        sc;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mwdata;
        logic [3:0]  mask;
    } vec_t;

    vec_t tbl[12];

    ysyx_25050147_lsu_ctrl #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_tag(resp_tag), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
`ifdef YSYX_25050147_LSU_PERF_EN
        , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: expected bus/response values from the load/store rules using plain arithmetic.
    function automatic void model(inout vec_t v);
        int nb, off;
        logic legal;
        longint unsigned val, w;
        nb  = 1 << v.op[1:0];
        off = int'(v.addr % 4);
        if (v.wen) legal = (v.op == 0 || v.op == 1 || v.op == 2);
        else       legal = (v.op == 0 || v.op == 1 || v.op == 2 || v.op == 4 || v.op == 5);
        v.sc = !legal || ((v.addr % nb) != 0);
        v.mask = 4'(((1 << nb) - 1) << off);
        w = v.wdata;
        v.mwdata = v.wen ? 32'((w % (64'd1 << (8 * nb))) << (8 * off)) : 32'd0;
        if (v.sc || v.wen || v.merr) begin
            v.rdata = 32'd0;
        end else begin
            w   = v.word;
            val = (w >> (8 * off)) % (64'd1 << (8 * nb));
            if (!v.op[2] && nb < 4 && val >= (64'd1 << (8 * nb - 1)))
                val = val + (64'd1 << 32) - (64'd1 << (8 * nb));
            v.rdata = val[31:0];
        end
        v.err = v.sc ? 1'b1 : v.merr;
    endfunction

    task automatic check_bus(input vec_t v);
        chk("mem_req_valid", mem_req_valid, 1);
        chk("mem_req_wen", mem_req_wen, v.wen);
        chk("mem_req_addr", mem_req_addr, v.addr & 32'hFFFF_FFFC);
        chk("mem_req_wdata", mem_req_wdata, v.mwdata);
        chk("mem_req_wmask", mem_req_wmask, v.mask);
        chk("req_ready_busy", req_ready, 0);
        chk("mem_resp_ready_req", mem_resp_ready, 0);
    endtask

    task automatic check_resp(input vec_t v, input logic [TAG_W-1:0] tag);
        chk("resp_valid", resp_valid, 1);
        chk("resp_rdata", resp_rdata, v.rdata);
        chk("resp_tag", resp_tag, tag);
        chk("resp_err", resp_err, v.err);
        chk("req_ready_resp", req_ready, 0);
        chk("mem_req_valid_resp", mem_req_valid, 0);
    endtask

    task automatic run_txn(input vec_t v, input logic [TAG_W-1:0] tag,
                           input int dreq, input int dresp, input int dout);
        req_valid = 1'b1;
        req_wen   = v.wen;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_tag   = tag;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_tag   = TAG_W'($urandom);
        if (v.sc) begin
            chk("shortcut_no_bus", mem_req_valid, 0);
        end else begin
            for (int i = 0; i < dreq; i++) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = $urandom;
                check_bus(v);
                step();
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            check_bus(v);
            step();
            mem_req_ready = 1'b0;
            chk("mem_req_drop", mem_req_valid, 0);
            for (int i = 0; i < dresp; i++) begin
                chk("mem_resp_ready_wait", mem_resp_ready, 1);
                chk("req_ready_wait", req_ready, 0);
                chk("resp_valid_wait", resp_valid, 0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = v.word;
            mem_resp_err   = v.merr;
            chk("mem_resp_ready_wait", mem_resp_ready, 1);
            step();
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
            mem_resp_err   = 1'($urandom);
        end
        for (int i = 0; i < dout; i++) begin
            check_resp(v, tag);
            step();
        end
        resp_ready = 1'b1;
        check_resp(v, tag);
        step();
        resp_ready   = 1'b0;
        mem_resp_err = 1'b0;
        chk("resp_valid_done", resp_valid, 0);
        chk("req_ready_done", req_ready, 1);
    endtask

    task automatic check_all_zero();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_wen", mem_req_wen, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_mem_req_wdata", mem_req_wdata, 0);
        chk("rst_mem_req_wmask", mem_req_wmask, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
    endtask

    initial begin
        vec_t v;
        //          wen   op      addr          wdata         word          merr  sc    err   rdata         mwdata        mask
        tbl[0]  = '{1'b0, 3'b000, 32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 1'b0, 1'b0, 32'hFFFFFF80, 32'h0,        4'b1000};
        tbl[1]  = '{1'b0, 3'b100, 32'h80000003, 32'h0,        32'h80FF1234, 1'b0, 1'b0, 1'b0, 32'h00000080, 32'h0,        4'b1000};
        tbl[2]  = '{1'b0, 3'b001, 32'h80000002, 32'h0,        32'h80010000, 1'b0, 1'b0, 1'b0, 32'hFFFF8001, 32'h0,        4'b1100};
        tbl[3]  = '{1'b0, 3'b101, 32'h80000002, 32'h0,        32'h80010000, 1'b0, 1'b0, 1'b0, 32'h00008001, 32'h0,        4'b1100};
        tbl[4]  = '{1'b0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        4'b1111};
        tbl[5]  = '{1'b1, 3'b000, 32'h80000001, 32'h123456AB, 32'h55555555, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000AB00, 4'b0010};
        tbl[6]  = '{1'b1, 3'b001, 32'h80000002, 32'hCAFE1234, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h12340000, 4'b1100};
        tbl[7]  = '{1'b1, 3'b010, 32'h80000006, 32'h11111111, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000};
        tbl[8]  = '{1'b0, 3'b001, 32'h80000001, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000};
        tbl[9]  = '{1'b0, 3'b011, 32'h80000000, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000};
        tbl[10] = '{1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000};
        tbl[11] = '{1'b0, 3'b000, 32'h80000000, 32'h0,        32'hAAAAAA7F, 1'b0, 1'b0, 1'b0, 32'h0000007F, 32'h0,        4'b0001};

        #1 reset_n = 1'b0;
        #1 check_all_zero();
        step();
        step();
        chk("rst_held_req_ready", req_ready, 0);
        reset_n = 1'b1;
        #1 chk("rst_release_req_ready", req_ready, 1);
        step();

        resp_ready = 1'b1;
        step();
        chk("idle_resp_ready_no_effect", resp_valid, 0);
        chk("idle_req_ready", req_ready, 1);
        resp_ready = 1'b0;

        for (int i = 0; i < 12; i++)
            run_txn(tbl[i], TAG_W'(i + 1), 0, 0, 0);

        // Back-pressure on every handshake with a bus error on a word load.
        v = '{1'b0, 3'b010, 32'h80000010, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'b1111};
        run_txn(v, 5'h1A, 3, 5, 2);

        // Reset asserted mid-transaction while the bus response is outstanding.
        req_valid = 1'b1; req_wen = 1'b0; req_op = 3'b010; req_addr = 32'h80000008; req_tag = 5'h03;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("pre_rst_wait", mem_resp_ready, 1);
        reset_n = 1'b0;
        #1 check_all_zero();
`ifdef YSYX_25050147_LSU_PERF_EN
        chk("perf_ld_rst", perf_ld_cnt, 0);
        chk("perf_st_rst", perf_st_cnt, 0);
        chk("perf_wait_rst", perf_wait_cnt, 0);
`endif
        step();
        check_all_zero();
        reset_n = 1'b1;
        #1 chk("post_rst_req_ready", req_ready, 1);
        step();
        v = '{1'b0, 3'b010, 32'h80000008, 32'h0, 32'hA5A5F00D, 1'b0, 1'b0, 1'b0, 32'hA5A5F00D, 32'h0, 4'b1111};
        run_txn(v, 5'h07, 0, 0, 0);
`ifdef YSYX_25050147_LSU_PERF_EN
        chk("perf_ld_after", perf_ld_cnt, 1);
        chk("perf_st_after", perf_st_cnt, 0);
        chk("perf_wait_after", perf_wait_cnt, 2);
`endif

        for (int n = 0; n < 200; n++) begin
            v.wen   = 1'($urandom);
            v.op    = 3'($urandom);
            v.addr  = 32'h8000_0000 | ($urandom & 32'hFF);
            v.wdata = $urandom;
            v.word  = $urandom;
            v.merr  = ($urandom_range(0, 7) == 0);
            model(v);
            run_txn(v, TAG_W'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
